// File: rtl/aes_pkg.sv
// Shared AES sequencer constants and FSM encoding.
package aes_pkg;

    localparam int unsigned AES_NR128 = 10;
    localparam int unsigned AES_DW    = 128;
    localparam int unsigned RK_IDX_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ROUND = ST_ROUND,
        S_DONE  = ST_DONE
    } aes_fsm_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns the state register and steps one
// round per cycle through an external combinational round datapath.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR128,
    parameter int unsigned DW = AES_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [DW-1:0]       rk_in,
    output logic [DW-1:0]       rnd_state,
    output logic                rnd_last,
    input  logic [DW-1:0]       rnd_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                busy
);

    localparam int unsigned RW = $clog2(NR + 1);

    aes_fsm_e                fsm_q, fsm_d;
    logic [RW-1:0]           round_q, round_d;
    logic [DW-1:0]           state_q, state_d;
    logic                    in_ready_q, out_valid_q, busy_q, rnd_last_q;
    logic [RK_IDX_W-1:0]     rk_idx_q;

    // Next-state: flush overrides everything; the final round holds the counter at NR.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        if (flush) begin
            fsm_d   = S_IDLE;
            round_d = '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = in_data ^ rk_in;
                        round_d = RW'(1);
                        fsm_d   = S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_d = rnd_result;
                    if (round_q == RW'(NR)) begin
                        fsm_d = S_DONE;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_d   = S_IDLE;
                        round_d = '0;
                    end
                end
                default: begin
                    fsm_d   = S_IDLE;
                    round_d = '0;
                end
            endcase
        end
    end

    // FSM, round counter, state register and registered output decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            round_q     <= '0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rnd_last_q  <= 1'b0;
            rk_idx_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            state_q     <= state_d;
            in_ready_q  <= (fsm_d == S_IDLE);
            out_valid_q <= (fsm_d == S_DONE);
            busy_q      <= (fsm_d != S_IDLE);
            rnd_last_q  <= (fsm_d == S_ROUND) && (round_d == RW'(NR));
            rk_idx_q    <= (fsm_d == S_ROUND) ? RK_IDX_W'(round_d) : '0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign rnd_last  = rnd_last_q;
    assign rk_idx    = rk_idx_q;
    assign rnd_state = state_q;
    assign out_data  = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with a behavioural AES round datapath and key
// schedule; ciphertexts are scoreboarded against published AES-128 vectors.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int unsigned NR = AES_NR128;

    logic                clk = 1'b0;
    logic                rst_n, flush, in_valid, in_ready, rnd_last;
    logic                out_valid, out_ready, busy;
    logic [127:0]        in_data, rk_in, rnd_state, rnd_result, out_data;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [127:0]        cur_key, drv_exp;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    logic [127:0] sb[$];
    int unsigned  acc_cyc[$];

    aes_round_ctrl #(.NR(NR), .DW(AES_DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk_in(rk_in),
        .rnd_state(rnd_state), .rnd_last(rnd_last), .rnd_result(rnd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES reference helpers ----------------
    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv  = 8'h01;
        logic [7:0] base = b;
        logic [7:0] e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[0]) inv = gmul(inv, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        if (b == 8'h00) inv = 8'h00;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t, u, v;
        for (int i = 0; i < 16; i++) t[8*i +: 8] = sbox(s[8*i +: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                u[8*(r+4*c) +: 8] = t[8*(r+4*((c+r)%4)) +: 8];
        v = u;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = u[8*(4*c)   +: 8];
                a1 = u[8*(4*c+1) +: 8];
                a2 = u[8*(4*c+2) +: 8];
                a3 = u[8*(4*c+3) +: 8];
                v[8*(4*c)   +: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
                v[8*(4*c+1) +: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
                v[8*(4*c+2) +: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
                v[8*(4*c+3) +: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return v ^ rk;
    endfunction

    function automatic logic [127:0] key_rk(input logic [127:0] key, input logic [3:0] n);
        logic [31:0] w0, w1, w2, w3, tmp;
        logic [7:0]  rcon = 8'h01;
        w0 = key[31:0]; w1 = key[63:32]; w2 = key[95:64]; w3 = key[127:96];
        for (int r = 1; r <= int'(n); r++) begin
            tmp = {w3[7:0], w3[31:24], w3[23:16], w3[15:8]};
            for (int j = 0; j < 4; j++) tmp[8*j +: 8] = sbox(tmp[8*j +: 8]);
            tmp[7:0] = tmp[7:0] ^ rcon;
            rcon = xt(rcon);
            w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        end
        return {w3, w2, w1, w0};
    endfunction

    assign rk_in      = key_rk(cur_key, rk_idx);
    assign rnd_result = aes_round(rnd_state, rk_in, rnd_last);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: push on accept, pop on output handshake, drop on flush.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (flush) begin
            if (busy && sb.size() > 0) void'(sb.pop_front());
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_out", 128'(sb.size()), 128'd1);
                else chk("ciphertext", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) begin
                sb.push_back(drv_exp);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] ct);
        in_data  = bswap(pt);
        drv_exp  = bswap(ct);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 128'(sb.size()), 128'd0);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_busy"},      128'(busy),      128'd0);
        chk({tag, "_rnd_last"},  128'(rnd_last),  128'd0);
        chk({tag, "_rk_idx"},    128'(rk_idx),    128'd0);
    endtask

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_SP  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic [127:0] b2b_pt[3];
    logic [127:0] b2b_ct[3];

    initial begin
        b2b_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        b2b_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        b2b_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        b2b_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        b2b_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        b2b_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; cur_key = bswap(K_C1); drv_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1 with round-sequencing checks
        in_data  = bswap(PT_C1);
        drv_exp  = bswap(CT_C1);
        in_valid = 1'b1;
        @(negedge clk);
        chk("c1_rk_idx_T", 128'(rk_idx), 128'd0);
        chk("c1_in_ready_T", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 1; k <= int'(NR); k++) begin
            @(negedge clk);
            chk($sformatf("c1_rk_idx_T%0d", k), 128'(rk_idx), 128'(k));
            chk($sformatf("c1_rnd_last_T%0d", k), 128'(rnd_last), 128'(k == int'(NR)));
            chk($sformatf("c1_out_valid_T%0d", k), 128'(out_valid), 128'd0);
        end
        @(negedge clk);
        chk("c1_out_valid_T11", 128'(out_valid), 128'd1);
        drain(5);

        // Backpressure: output held stable while out_ready is low
        cur_key   = bswap(K_SP);
        out_ready = 1'b0;
        send(PT_B, CT_B);
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_data", out_data, bswap(CT_B));
            if (j < 4) @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(out_valid), 128'd1);
        tick();
        @(negedge clk);
        chk("bp_after_in_ready", 128'(in_ready), 128'd1);
        chk("bp_after_out_valid", 128'(out_valid), 128'd0);
        chk("bp_sb_empty", 128'(sb.size()), 128'd0);
        tick();

        // Back-to-back with in_valid held high
        acc_cyc.delete();
        in_valid = 1'b1;
        for (int v = 0; v < 3; v++) begin
            in_data = bswap(b2b_pt[v]);
            drv_exp = bswap(b2b_ct[v]);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (in_ready) break;
            end
            chk("b2b_accept", 128'(in_ready), 128'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        drain(40);
        chk("b2b_count", 128'(acc_cyc.size()), 128'd3);
        for (int i = 0; i + 1 < acc_cyc.size(); i++)
            chk("b2b_gap", 128'(acc_cyc[i+1] - acc_cyc[i]), 128'(NR + 2));

        // Abort mid-round, including flush racing a new in_valid in IDLE
        cur_key  = bswap(K_C1);
        in_data  = bswap(PT_C1);
        drv_exp  = bswap(CT_C1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        in_valid = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        chk("abort_not_accepted", 128'(busy), 128'd0);
        chk("abort_sb_empty", 128'(sb.size()), 128'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("abort_no_out_valid", 128'(seen), 128'd0);
        end
        tick();
        send(PT_C1, CT_C1);
        drain(20);

        // Asynchronous reset mid-round
        send(PT_C1, CT_C1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        chk("arst_out_data", out_data, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(PT_C1, CT_C1);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
